// File: rtl/minibus_arbiter_rr_if.sv
// Channel-side request/response bundle and minibus master signals of the arbiter.
// master = arbiter side, slave = requesting channels plus minibus slave.
interface minibus_arbiter_rr_if #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0]        ch_ren;
   logic [NUM_CH-1:0]        ch_wen;
   logic [NUM_CH*ADDR_W-1:0] ch_addr;
   logic [NUM_CH*DATA_W-1:0] ch_wdata;
   logic [NUM_CH*2-1:0]      ch_width;
   logic [NUM_CH-1:0]        ch_hit;
   logic [NUM_CH-1:0]        ch_err;
   logic [DATA_W-1:0]        ch_rdata;
   logic                     bus_ren;
   logic                     bus_wen;
   logic [ADDR_W-1:0]        bus_addr;
   logic [DATA_W-1:0]        bus_wdata;
   logic [1:0]               bus_width;
   logic                     bus_ack;
   logic                     bus_err;
   logic [DATA_W-1:0]        bus_rdata;
   logic [ID_W-1:0]          grant_id;

   modport master (
      input  ch_ren, ch_wen, ch_addr, ch_wdata, ch_width,
      input  bus_ack, bus_err, bus_rdata,
      output ch_hit, ch_err, ch_rdata,
      output bus_ren, bus_wen, bus_addr, bus_wdata, bus_width, grant_id
   );

   modport slave (
      output ch_ren, ch_wen, ch_addr, ch_wdata, ch_width,
      output bus_ack, bus_err, bus_rdata,
      input  ch_hit, ch_err, ch_rdata,
      input  bus_ren, bus_wen, bus_addr, bus_wdata, bus_width, grant_id
   );
endinterface

// File: rtl/minibus_arbiter_rr.sv
// N-channel minibus master arbiter: fixed or round-robin grant, one registered bus
// transaction at a time, bus timeout and per-channel completion/error pulses.
//
// state  | meaning
// S_IDLE | no transaction; winner latched on the edge leaving this state
// S_BUSY | strobe asserted, waiting for bus_ack or timeout
// S_DONE | ch_hit/ch_err/ch_rdata presented for one cycle
module minibus_arbiter_rr #(
   parameter int NUM_CH      = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int RR_MODE     = 1,
   parameter int TIMEOUT_CYC = 16
) (
   input logic                  CLK,
   input logic                  nRST,
   minibus_arbiter_rr_if.master mb
);
   localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0] TO_LOAD = (TIMEOUT_CYC > 0) ? TO_W'(TIMEOUT_CYC - 1) : '0;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [NUM_CH-1:0]   w_req;
   logic                w_any_req;
   logic                w_found;
   int                  w_idx;
   logic [ID_W-1:0]     w_win;
   logic                w_win_wr;
   logic [ID_W-1:0]     w_rr_nxt;
   logic                w_timeout;
   logic [NUM_CH-1:0]   w_grant_oh;

   logic [ID_W-1:0]     r_rr_ptr;
   logic [ID_W-1:0]     r_grant;
   logic [TO_W-1:0]     r_cnt;
   logic                r_bus_ren;
   logic                r_bus_wen;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [1:0]          r_width;
   logic [NUM_CH-1:0]   r_hit;
   logic [NUM_CH-1:0]   r_err;
   logic [DATA_W-1:0]   r_rdata;

   assign w_req      = mb.ch_ren | mb.ch_wen;
   assign w_any_req  = |w_req;
   assign w_win_wr   = mb.ch_wen[w_win];
   assign w_rr_nxt   = (w_win == ID_W'(NUM_CH - 1)) ? '0 : w_win + ID_W'(1);
   assign w_timeout  = (TIMEOUT_CYC != 0) && (r_cnt == '0);
   assign w_grant_oh = {{(NUM_CH-1){1'b0}}, 1'b1} << r_grant;

   always_comb begin
      w_win   = '0;
      w_found = 1'b0;
      w_idx   = 0;
      if (RR_MODE == 0) begin
         for (int k = NUM_CH - 1; k >= 0; k--)
            if (w_req[k]) w_win = ID_W'(k);
      end else begin
         // scan starts at the pointer and wraps past the top channel
         for (int k = 0; k < NUM_CH; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
            if (!w_found && w_req[w_idx]) begin
               w_found = 1'b1;
               w_win   = ID_W'(w_idx);
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_any_req) w_state_nxt = S_BUSY;
         S_BUSY:  if (mb.bus_ack || w_timeout) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_rr_ptr  <= '0;
         r_grant   <= '0;
         r_cnt     <= '0;
         r_bus_ren <= 1'b0;
         r_bus_wen <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_width   <= '0;
         r_hit     <= '0;
         r_err     <= '0;
         r_rdata   <= '0;
      end else begin
         r_hit   <= '0;
         r_err   <= '0;
         r_rdata <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_grant   <= w_win;
                  r_rr_ptr  <= w_rr_nxt;
                  r_cnt     <= TO_LOAD;
                  r_bus_ren <= ~w_win_wr;
                  r_bus_wen <= w_win_wr;
                  r_addr    <= mb.ch_addr[w_win*ADDR_W +: ADDR_W];
                  r_wdata   <= mb.ch_wdata[w_win*DATA_W +: DATA_W];
                  r_width   <= mb.ch_width[w_win*2 +: 2];
               end
            end
            S_BUSY: begin
               if (mb.bus_ack || w_timeout) begin
                  // ack outranks a timeout landing in the same cycle
                  r_bus_ren <= 1'b0;
                  r_bus_wen <= 1'b0;
                  r_hit     <= w_grant_oh;
                  r_err     <= mb.bus_ack ? ({NUM_CH{mb.bus_err}} & w_grant_oh) : w_grant_oh;
                  r_rdata   <= (mb.bus_ack && r_bus_ren) ? mb.bus_rdata : '0;
               end else begin
                  r_cnt <= r_cnt - TO_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign mb.bus_ren   = r_bus_ren;
   assign mb.bus_wen   = r_bus_wen;
   assign mb.bus_addr  = r_addr;
   assign mb.bus_wdata = r_wdata;
   assign mb.bus_width = r_width;
   assign mb.ch_hit    = r_hit;
   assign mb.ch_err    = r_err;
   assign mb.ch_rdata  = r_rdata;
   assign mb.grant_id  = r_grant;
endmodule
